// File: rtl/sub4_serial.sv
`default_nettype none
// ============================================================================
//  Module   : sub4_serial
//  Function : Bit-serial W-bit subtractor, diff = a - b - bin (mod 2^W),
//             LSB first through one full-subtractor cell, with unsigned
//             borrow-out and start/busy/done handshake.
//  Options  : define SUB4_SERIAL_OVF_EN to add the signed-overflow port
//             ovf_o together with its latched operand MSBs.
//  Revision : 1.0  initial release
// ============================================================================
module sub4_serial #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] diff_o,
    output logic         bout_o
`ifdef SUB4_SERIAL_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-2:0]    p_q;       // partial result; the newest bit lands in the MSB
    logic            br_q;
    logic [CW-1:0]   count_q;
    logic [W-1:0]    diff_q;
    logic            bout_q;
`ifdef SUB4_SERIAL_OVF_EN
    logic            a_msb_q;
    logic            b_msb_q;
    logic            ovf_q;
`endif

    // Full-subtractor cell on the current LSBs.
    logic            bit_d;
    logic            br_d;
    logic [W-2:0]    p_d;
    logic            last_d;

    assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last_d = (count_q == CW'(W - 1));

    // Partial register shifts right, new difference bit entering at the top;
    // the W=2 case has a one-bit partial register with nothing to shift.
    generate
        if (W == 2) begin : g_p_single
            assign p_d = bit_d;
        end else begin : g_p_shift
            assign p_d = {bit_d, p_q[W-2:1]};
        end
    endgenerate

    // Control FSM plus datapath registers; results are only written on the
    // edge that enters DONE so they hold through IDLE and the next SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            br_q    <= 1'b0;
            count_q <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB4_SERIAL_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= bin_i;
                        count_q <= '0;
`ifdef SUB4_SERIAL_OVF_EN
                        a_msb_q <= a_i[W-1];
                        b_msb_q <= b_i[W-1];
`endif
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    br_q    <= br_d;
                    p_q     <= p_d;
                    count_q <= count_q + CW'(1);
                    if (last_d) begin
                        diff_q  <= {bit_d, p_q};
                        bout_q  <= br_d;
`ifdef SUB4_SERIAL_OVF_EN
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q == S_SHIFT);
    assign done_o = (state_q == S_DONE);
    assign diff_o = diff_q;
    assign bout_o = bout_q;
`ifdef SUB4_SERIAL_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule
`default_nettype wire
